// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the MEM stage: load/store opcodes, byte-enable constants,
// FSM state encoding and opcode classification helpers.
package cpu_mem_pkg;

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2B;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mem_state_t;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_mem(input logic [7:0] op);
        return is_load(op) | is_store(op);
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return |a;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-outstanding req/ack data bus between the MEM stage (master) and memory (slave).
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering: store byte-enables/replicated data, load extract and extend.
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [7:0]  i_st_op,
    input  logic [1:0]  i_st_lane,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [7:0]  i_ld_op,
    input  logic [1:0]  i_ld_lane,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ldata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_ld_lane, 3'b000} +: 8];
    assign w_half = i_ld_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_be    = BE_NONE;
        o_wdata = i_st_data;
        case (i_st_op)
            OP_SB: begin
                o_be    = 4'b0001 << i_st_lane;
                o_wdata = {4{i_st_data[7:0]}};
            end
            OP_SH: begin
                o_be    = i_st_lane[1] ? BE_HI_HALF : BE_LO_HALF;
                o_wdata = {2{i_st_data[15:0]}};
            end
            OP_SW:   o_be = BE_WORD;
            default: ;
        endcase
    end

    always_comb begin
        o_ldata = i_rdata;
        case (i_ld_op)
            OP_LB:   o_ldata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_ldata = {24'h0, w_byte};
            OP_LH:   o_ldata = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_ldata = {16'h0, w_half};
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues loads/stores on a req/ack bus, stalls the pipe until ack, registers writeback.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with a bus_err_o pulse.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid_i,
    input  logic [7:0]                aluop_i,
    input  logic [31:0]               mem_addr_i,
    input  logic [31:0]               reg2_i,
    input  logic [4:0]                wd_i,
    input  logic                      wreg_i,
    input  logic [31:0]               wdata_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    mem_access_unit_if.master         dbus,
    output logic                      wb_valid_o,
    output logic [4:0]                wd_o,
    output logic                      wreg_o,
    output logic [31:0]               wdata_o,
    output logic                      bus_err_o
);
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    mem_state_t  r_state, w_state_nxt;
    logic        r_req, r_we, r_wreg, r_flushed, r_done, r_err;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic [7:0]  r_op;
    logic [1:0]  r_lane;
    logic [4:0]  r_wd;
    logic [CW-1:0] r_cnt;
    logic        r_wb_valid, r_wb_wreg;
    logic [4:0]  r_wb_wd;
    logic [31:0] r_wb_wdata;

    logic        w_misalign, w_live, w_accept, w_align_err, w_pass, w_tmo;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data, w_ld_data;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = is_misaligned(aluop_i, mem_addr_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // EX is still holding the just-completed op in the cycle after completion; ignore it.
    assign w_live      = ex_valid_i & ~flush_i & ~r_done;
    assign w_accept    = (r_state == ST_IDLE) & w_live & is_mem(aluop_i) & ~w_misalign;
    assign w_align_err = (r_state == ST_IDLE) & w_live & is_mem(aluop_i) & w_misalign;
    assign w_pass      = (r_state == ST_IDLE) & w_live & ~is_mem(aluop_i);
    assign w_tmo       = (ACK_TIMEOUT != 0) && (r_state == ST_REQ) && !dbus.ack
                         && (r_cnt == CW'(ACK_TIMEOUT - 1));

    mem_lane_align u_align (
        .i_st_op   (aluop_i),
        .i_st_lane (mem_addr_i[1:0]),
        .i_st_data (reg2_i),
        .o_be      (w_st_be),
        .o_wdata   (w_st_data),
        .i_ld_op   (r_op),
        .i_ld_lane (r_lane),
        .i_rdata   (dbus.rdata),
        .o_ldata   (w_ld_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        stall_o     = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                w_state_nxt = ST_REQ;
                stall_o     = 1'b1;
            end
            ST_REQ: begin
                stall_o = 1'b1;
                if (dbus.ack || w_tmo) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req      <= 1'b0;  r_we       <= 1'b0;  r_addr    <= '0;
            r_be       <= '0;    r_wdata    <= '0;    r_op      <= '0;
            r_lane     <= '0;    r_wd       <= '0;    r_wreg    <= 1'b0;
            r_flushed  <= 1'b0;  r_done     <= 1'b0;  r_err     <= 1'b0;
            r_cnt      <= '0;    r_wb_valid <= 1'b0;  r_wb_wd   <= '0;
            r_wb_wreg  <= 1'b0;  r_wb_wdata <= '0;
        end else begin
            r_done     <= (r_state == ST_REQ) && (w_state_nxt == ST_IDLE);
            r_wb_valid <= 1'b0;
            r_err      <= w_align_err;
            if (w_accept) begin
                r_req     <= 1'b1;
                r_we      <= is_store(aluop_i);
                r_addr    <= {mem_addr_i[31:2], 2'b00};
                r_be      <= w_st_be;
                r_wdata   <= w_st_data;
                r_op      <= aluop_i;
                r_lane    <= mem_addr_i[1:0];
                r_wd      <= wd_i;
                r_wreg    <= wreg_i;
                r_flushed <= 1'b0;
                r_cnt     <= '0;
            end
            if (w_pass) begin
                r_wb_valid <= 1'b1;
                r_wb_wd    <= wd_i;
                r_wb_wreg  <= wreg_i;
                r_wb_wdata <= wdata_i;
            end
            if (r_state == ST_REQ) begin
                r_cnt <= r_cnt + CW'(1);
                if (flush_i) r_flushed <= 1'b1;
                // Ack is tested before the timeout so a last-cycle ack still completes normally.
                if (dbus.ack) begin
                    r_req      <= 1'b0;
                    r_wb_valid <= ~(r_flushed | flush_i);
                    r_wb_wd    <= r_wd;
                    r_wb_wreg  <= r_wreg & ~r_we;
                    r_wb_wdata <= w_ld_data;
                end else if (w_tmo) begin
                    r_req <= 1'b0;
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign dbus.req   = r_req;
    assign dbus.we    = r_we;
    assign dbus.addr  = r_addr;
    assign dbus.be    = r_be;
    assign dbus.wdata = r_wdata;
    assign wb_valid_o = r_wb_valid;
    assign wd_o       = r_wb_wd;
    assign wreg_o     = r_wb_wreg;
    assign wdata_o    = r_wb_wdata;
    assign bus_err_o  = r_err;
endmodule
